// File: rtl/arm_dp_pkg.sv
// Shared ARMv4 data-processing definitions: opcodes, condition codes, ALU selects,
// controller state encoding and opcode classification helpers.
package arm_dp_pkg;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [3:0] ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC1, ST_EXEC2, ST_DONE} state_e;
  typedef enum logic [1:0] {CLS_LOGIC, CLS_ADD, CLS_SUB} op_class_e;

  function automatic op_class_e op_class(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_ADC, OP_CMN:                 return CLS_ADD;
      OP_SUB, OP_RSB, OP_SBC, OP_RSC, OP_CMP: return CLS_SUB;
      default:                                return CLS_LOGIC;
    endcase
  endfunction

  // TST/TEQ/CMP/CMN: flags only, never write rd
  function automatic logic is_test(input logic [3:0] opc);
    return opc[3:2] == 2'b10;
  endfunction

  function automatic logic is_two_pass(input logic [3:0] opc);
    return (opc == OP_ADC) || (opc == OP_SBC) || (opc == OP_RSC);
  endfunction

  function automatic logic is_rev(input logic [3:0] opc);
    return (opc == OP_RSB) || (opc == OP_RSC);
  endfunction

  function automatic logic [3:0] alu_sel_pass1(input logic [3:0] opc);
    case (opc)
      OP_BIC, OP_TST: return ALU_AND;
      OP_TEQ:         return ALU_EOR;
      OP_CMN, OP_ADC: return ALU_ADD;
      OP_CMP, OP_SBC: return ALU_SUB;
      OP_RSC:         return ALU_RSB;
      default:        return opc;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode request, shared-ALU and writeback signals of the issue controller.
// master = controller side, slave = decode/ALU/writeback side.
interface alu_issue_ctrl_if #(
  parameter int REG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       opcode;
  logic [3:0]       cond;
  logic             set_flags;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [REG_W-1:0] rd;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_sel;
  logic [63:0]      alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [REG_W-1:0] res_rd;
  logic             res_we;
  logic [3:0]       nzcv;

  modport master (
    input  req_valid, opcode, cond, set_flags, op_a, op_b, rd, alu_out, res_ready,
    output req_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_rd, res_we, nzcv
  );

  modport slave (
    output req_valid, opcode, cond, set_flags, op_a, op_b, rd, alu_out, res_ready,
    input  req_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_rd, res_we, nzcv
  );
endinterface

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluation against {N,Z,C,V}; purely combinational.
// Zero latency, no handshake.
module arm_cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues ARM DP ops onto the shared ALU, owns NZCV; result 1/2/3 cycles after accept
// (cond fail / single / carry-in); result held in DONE until res_ready, one op in flight.
module alu_issue_ctrl
  import arm_dp_pkg::*;
#(
  parameter int         REG_W      = 4,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.master bus
);
  state_e           state, state_nxt;
  logic [31:0]      alu_a_q, alu_b_q, res_data_q, r;
  logic [3:0]       alu_sel_q, opc_q, nzcv_q, nzcv_nxt;
  logic [REG_W-1:0] res_rd_q;
  logic             s_q, a31_q, b31_q, c1_q, res_we_q;
  logic             cond_pass, cy, sa31, sb31, req_ready_c, res_valid_c;
  logic             unused_alu_hi;

  assign unused_alu_hi = ^bus.alu_out[63:33];

  arm_cond_check u_cond (
    .cond (bus.cond),
    .nzcv (nzcv_q),
    .pass (cond_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) state_nxt = cond_pass ? ST_EXEC1 : ST_DONE;
      ST_EXEC1: state_nxt = is_two_pass(opc_q) ? ST_EXEC2 : ST_DONE;
      ST_EXEC2: state_nxt = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_c = 1'b0;
    res_valid_c = 1'b0;
    case (state)
      ST_IDLE: req_ready_c = 1'b1;
      ST_DONE: res_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Flags come from the final pass only; carry/borrow ORs in the pass-1 bit 32.
  always_comb begin
    r        = bus.alu_out[31:0];
    cy       = bus.alu_out[32] | c1_q;
    sa31     = is_rev(opc_q) ? b31_q : a31_q;
    sb31     = is_rev(opc_q) ? a31_q : b31_q;
    nzcv_nxt = {r[31], (r == 32'd0), nzcv_q[1:0]};
    case (op_class(opc_q))
      CLS_ADD: nzcv_nxt[1:0] = {cy, (a31_q == b31_q) && (r[31] != a31_q)};
      CLS_SUB: nzcv_nxt[1:0] = {~cy, (sa31 != sb31) && (r[31] != sa31)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      opc_q      <= '0;
      s_q        <= 1'b0;
      a31_q      <= 1'b0;
      b31_q      <= 1'b0;
      c1_q       <= 1'b0;
      nzcv_q     <= RESET_NZCV;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_we_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          opc_q    <= bus.opcode;
          s_q      <= bus.set_flags;
          a31_q    <= bus.op_a[31];
          b31_q    <= bus.op_b[31];
          c1_q     <= 1'b0;
          res_rd_q <= bus.rd;
          if (cond_pass) begin
            alu_a_q   <= bus.op_a;
            alu_b_q   <= (bus.opcode == OP_BIC) ? ~bus.op_b : bus.op_b;
            alu_sel_q <= alu_sel_pass1(bus.opcode);
          end else begin
            res_we_q  <= 1'b0;
          end
        end
        ST_EXEC1, ST_EXEC2: begin
          if (state == ST_EXEC1 && is_two_pass(opc_q)) begin
            // Pass 2 folds in the carry: +C for ADC, -(~C) for SBC/RSC
            alu_a_q   <= bus.alu_out[31:0];
            alu_b_q   <= {31'd0, (opc_q == OP_ADC) ? nzcv_q[1] : ~nzcv_q[1]};
            alu_sel_q <= (opc_q == OP_ADC) ? ALU_ADD : ALU_SUB;
            c1_q      <= bus.alu_out[32];
          end else begin
            res_data_q <= r;
            res_we_q   <= !is_test(opc_q);
            if (s_q || is_test(opc_q)) nzcv_q <= nzcv_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_we    = res_we_q;
  assign bus.nzcv      = nzcv_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural shared ALU on the interface.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  alu_issue_ctrl_if #(.REG_W(4)) bus ();

  alu_issue_ctrl #(.REG_W(4), .RESET_NZCV(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: 64-bit zero-extended arithmetic, 15 = pass A
  always_comb begin
    case (bus.alu_sel)
      4'h0:    bus.alu_out = {32'd0, bus.alu_a & bus.alu_b};
      4'h1:    bus.alu_out = {32'd0, bus.alu_a ^ bus.alu_b};
      4'h2:    bus.alu_out = {32'd0, bus.alu_a} - {32'd0, bus.alu_b};
      4'h3:    bus.alu_out = {32'd0, bus.alu_b} - {32'd0, bus.alu_a};
      4'h4:    bus.alu_out = {32'd0, bus.alu_a} + {32'd0, bus.alu_b};
      4'hC:    bus.alu_out = {32'd0, bus.alu_a | bus.alu_b};
      4'hD:    bus.alu_out = {32'd0, bus.alu_b};
      4'hF:    bus.alu_out = {32'd0, bus.alu_a};
      default: bus.alu_out = 64'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request, then waits (bounded) until res_valid; lat counts edges from accept.
  task automatic issue(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] r);
    check("req_ready_before_issue", bus.req_ready, 1);
    bus.opcode    = opc;
    bus.cond      = cnd;
    bus.set_flags = s;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.rd        = r;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    bus.opcode = '0; bus.cond = '0; bus.set_flags = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_nzcv", bus.nzcv, 4'b0000);
    check("rst_res_we", bus.res_we, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_rd", bus.res_rd, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD S AL: FFFFFFFF + 1
    issue(4'h4, 4'hE, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'd3);
    check("add_lat", lat, 2);
    check("add_data", bus.res_data, 32'h0);
    check("add_we", bus.res_we, 1);
    check("add_rd", bus.res_rd, 4'd3);
    check("add_nzcv", bus.nzcv, 4'b0110);
    retire();
    check("add_released", bus.res_valid, 0);

    // SUB S: 5 - 7
    issue(4'h2, 4'hE, 1'b1, 32'd5, 32'd7, 4'd1);
    check("sub_lat", lat, 2);
    check("sub_data", bus.res_data, 32'hFFFF_FFFE);
    check("sub_nzcv", bus.nzcv, 4'b1000);
    retire();

    // CMP 7,7 (flags without S, no write)
    issue(4'hA, 4'hE, 1'b0, 32'd7, 32'd7, 4'd2);
    check("cmp_we", bus.res_we, 0);
    check("cmp_nzcv", bus.nzcv, 4'b0110);
    retire();

    // ADC with C=1: 7FFFFFFF + 0 + 1
    issue(4'h5, 4'hE, 1'b1, 32'h7FFF_FFFF, 32'h0, 4'd4);
    check("adc_lat", lat, 3);
    check("adc_data", bus.res_data, 32'h8000_0000);
    check("adc_nzcv", bus.nzcv, 4'b1001);
    retire();

    // SBC with C=0: 5 - 5 - 1
    issue(4'h6, 4'hE, 1'b1, 32'd5, 32'd5, 4'd4);
    check("sbc_lat", lat, 3);
    check("sbc_data", bus.res_data, 32'hFFFF_FFFF);
    check("sbc_c", bus.nzcv[1], 0);
    check("sbc_nzcv", bus.nzcv, 4'b1000);
    retire();

    // MOV cond MI with N=1 passes; flags untouched without S
    issue(4'hD, 4'h4, 1'b0, 32'h0, 32'h1234_5678, 4'd6);
    check("mov_mi_lat", lat, 2);
    check("mov_mi_data", bus.res_data, 32'h1234_5678);
    check("mov_mi_nzcv", bus.nzcv, 4'b1000);
    retire();

    // BIC S: FF & ~0F; C,V preserved (0)
    issue(4'hE, 4'hE, 1'b1, 32'hFF, 32'h0F, 4'd7);
    check("bic_data", bus.res_data, 32'hF0);
    check("bic_we", bus.res_we, 1);
    check("bic_nzcv", bus.nzcv, 4'b0000);
    retire();

    // TEQ A5,A5 -> Z
    issue(4'h9, 4'hE, 1'b0, 32'hA5, 32'hA5, 4'd7);
    check("teq_we", bus.res_we, 0);
    check("teq_nzcv", bus.nzcv, 4'b0100);
    retire();

    // CMN 1 + FFFFFFFF -> Z, C
    issue(4'hB, 4'hE, 1'b0, 32'h1, 32'hFFFF_FFFF, 4'd7);
    check("cmn_lat", lat, 2);
    check("cmn_nzcv", bus.nzcv, 4'b0110);
    retire();

    // ADD cond NE with Z=1 fails
    issue(4'h4, 4'h1, 1'b1, 32'h1, 32'h1, 4'd5);
    check("ne_fail_lat", lat, 1);
    check("ne_fail_we", bus.res_we, 0);
    check("ne_fail_nzcv", bus.nzcv, 4'b0110);
    retire();

    // Cond NV never executes
    issue(4'h4, 4'hF, 1'b1, 32'h1, 32'h1, 4'd5);
    check("nv_lat", lat, 1);
    check("nv_we", bus.res_we, 0);
    check("nv_nzcv", bus.nzcv, 4'b0110);
    retire();

    // ADD cond EQ with Z=1 passes
    issue(4'h4, 4'h0, 1'b0, 32'd2, 32'd3, 4'd8);
    check("eq_lat", lat, 2);
    check("eq_data", bus.res_data, 32'd5);
    check("eq_we", bus.res_we, 1);
    retire();

    // Back-pressure: ORR held for 5 cycles
    bus.res_ready = 1'b0;
    issue(4'hC, 4'hE, 1'b0, 32'hF0, 32'h0F, 4'd9);
    check("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data", bus.res_data, 32'hFF);
      check("bp_res_rd", bus.res_rd, 4'd9);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", bus.res_valid, 0);
    check("bp_release_ready", bus.req_ready, 1);

    // Reset during EXEC2 of an ADC (C=1 from CMN)
    bus.opcode = 4'h5; bus.cond = 4'hE; bus.set_flags = 1'b1;
    bus.op_a = 32'h1; bus.op_b = 32'h1; bus.rd = 4'd2;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("exec2_res_valid", bus.res_valid, 0);
    check("exec2_alu_sel", bus.alu_sel, 4'h4);
    check("exec2_alu_b", bus.alu_b, 32'h1);
    check("exec2_alu_a", bus.alu_a, 32'h2);
    rst = 1'b1;
    #1;
    check("arst_nzcv", bus.nzcv, 4'b0000);
    check("arst_res_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_res_valid", bus.res_valid, 0);
    check("post_rst_nzcv", bus.nzcv, 4'b0000);
    check("post_rst_req_ready", bus.req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
